time_pack_utc: RTL and testbench
================================

# time_pack_utc

Converts a Beijing-local time, held as six BCD digits (hh:mm:ss), into the packed 18-bit UTC integer hhmmss (for example 63527 for 06:35:27) used on the time bus. It performs the inverse of the downstream time-unpacking block: it subtracts 8 hours with day wrap, then builds the integer by repeated constant addition instead of multipliers. It sits between the local clock/display digit registers and the GPS/time message path, and is triggered by a rising edge on `start`.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset rst_n, asynchronous, active-low; clock clk
- start  in  1  level request; the rising edge starts one conversion
- shi_1  in  4  local hour tens digit (BCD)
- shi_2  in  4  local hour units digit (BCD)
- fen_1  in  4  minute tens digit (BCD)
- fen_2  in  4  minute units digit (BCD)
- miao_1  in  4  second tens digit (BCD)
- miao_2  in  4  second units digit (BCD)
- shijian  out  18  packed UTC hhmmss integer; holds the last valid result
- sj_valid  out  1  one-cycle pulse when a conversion finishes (valid or error)
- err  out  1  one-cycle pulse coincident with sj_valid when the input was invalid
- busy  out  1  high whenever the FSM is not in IDLE

## Operation
- **Start detection.** A 2-flop shift register samples `start`. podge = tmp[0] & ~tmp[1]. A podge that occurs while not in IDLE is discarded.
- **States:** IDLE, CHECK, HOUR, MIN_T, MIN_U, SEC_T, SEC_U, DONE.
- **IDLE.** On podge, latch all six digits into internal registers and go to CHECK. Inputs may change after the latch.
- **CHECK.** The input is valid only if all of the following hold:
  - every digit is ≤ 9;
  - shi_1 ≤ 2;
  - shi_1*10 + shi_2 ≤ 23;
  - fen_1 ≤ 5;
  - miao_1 ≤ 5.
- **CHECK outcomes.**
  - Invalid: go to DONE with the error flag set.
  - Valid: acc ← 0, cnt ← h_utc, go to HOUR.
  - h_utc = h − 8 if h ≥ 8, else h + 16, where h = shi_1*10 + shi_2.
- **Accumulate states.** Each state has a fixed constant:
  - HOUR: 10000
  - MIN_T: 1000
  - MIN_U: 100
  - SEC_T: 10
  - SEC_U: 1
- **Per cycle in an accumulate state:**
  - If cnt ≠ 0: acc ← acc + constant, cnt ← cnt − 1.
  - Else: load cnt with the next digit (fen_1, fen_2, miao_1, miao_2) and advance to the next state. SEC_U advances to DONE.
- **DONE.**
  - Valid conversion: shijian ← acc and sj_valid ← 1.
  - Error: sj_valid ← 1, err ← 1, shijian is unchanged.
  - In both cases, return to IDLE.
- **Widths.** acc and shijian are 18-bit unsigned; the maximum value is 235959 < 2^18, so no overflow is possible. cnt is 5-bit (maximum 23).
- **Reset values:** shijian = 0, sj_valid = 0, err = 0, busy = 0, state = IDLE, tmp = 00. acc, cnt and the latched digits are all 0.

## Timing
- **Cycle reference.** E0 is the first clk edge at which `start` = 1 is sampled. The digits are latched at E1, and CHECK runs at E2.
- **Valid latency.** sj_valid goes high after edge E(8+S) and lasts exactly one cycle. S = h_utc + fen_1 + fen_2 + miao_1 + miao_2. The range is 8 cycles (S = 0) to 59 cycles (S = 51).
- **Invalid latency.** sj_valid and err go high after edge E3.
- **Result timing.** shijian updates on the same edge that raises sj_valid and is stable from then on.
- **busy** is high from E1 through the DONE cycle, and low in the cycle after sj_valid.
- **Re-trigger.** `start` held high produces exactly one conversion. A new conversion requires `start` to go low and then high again while in IDLE. The earliest accepted re-edge is the one that lands in the cycle after DONE.
- **Reset mid-conversion.** Everything is forced to its reset value immediately, and no sj_valid is produced.

## Test plan
- Local 08:00:00 → shijian = 0; sj_valid after edge E8; err = 0.
- Local 14:35:27 → shijian = 63527; sj_valid after E31 (S = 23).
- Local 07:59:59 → shijian = 235959 (day wrap, h_utc = 23); sj_valid after E59. Local 00:00:00 → 160000 at E24.
- Invalid inputs:
  - 24:00:00 → err and sj_valid after E3; shijian keeps its prior value.
  - 12:60:00 → err.
  - Digit value 10 → err.
- `start` pulsed again during a conversion (busy = 1) → ignored; only one sj_valid. A second clean edge after done → second conversion completes correctly.
- rst_n pulsed low mid-HOUR → all outputs 0 immediately, no sj_valid. A fresh start afterwards converts correctly.

Source files
------------

// File: rtl/time_pack_utc.sv
// ============================================================================
// Module   : time_pack_utc
// Brief    : Packs a Beijing-local BCD time (hh:mm:ss) into an 18-bit UTC
//            hhmmss integer by shifting 8 hours back and adding constants.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module time_pack_utc (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  shi_1,
    input  logic [3:0]  shi_2,
    input  logic [3:0]  fen_1,
    input  logic [3:0]  fen_2,
    input  logic [3:0]  miao_1,
    input  logic [3:0]  miao_2,
    output logic [17:0] shijian,
    output logic        sj_valid,
    output logic        err,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_HOUR  = 3'd2,
        S_MIN_T = 3'd3,
        S_MIN_U = 3'd4,
        S_SEC_T = 3'd5,
        S_SEC_U = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [1:0]  r_tmp;
    logic [3:0]  r_h1, r_h2, r_m1, r_m2, r_s1, r_s2;
    logic [17:0] r_acc;
    logic [4:0]  r_cnt;
    logic        r_err;

    logic        w_podge;
    logic [7:0]  w_h;
    logic [4:0]  w_h5;
    logic [4:0]  w_h_utc;
    logic        w_valid;
    logic        w_cnt_zero;
    logic [17:0] w_const;
    logic [3:0]  w_next_digit;

    assign w_podge    = r_tmp[0] & ~r_tmp[1];
    assign busy       = (r_state != S_IDLE);
    assign w_cnt_zero = (r_cnt == 5'd0);

    // h*10 built as h*8 + h*2 so no multiplier is inferred
    assign w_h     = {1'b0, r_h1, 3'b000} + {3'b000, r_h1, 1'b0} + {4'b0000, r_h2};
    assign w_h5    = w_h[4:0];
    assign w_h_utc = (w_h5 >= 5'd8) ? (w_h5 - 5'd8) : (w_h5 + 5'd16);
    assign w_valid = (r_h1 <= 4'd2) && (r_h2 <= 4'd9) && (w_h <= 8'd23) &&
                     (r_m1 <= 4'd5) && (r_m2 <= 4'd9) &&
                     (r_s1 <= 4'd5) && (r_s2 <= 4'd9);

    always_comb begin
        w_const      = 18'd0;
        w_next_digit = 4'd0;
        case (r_state)
            S_HOUR:  begin w_const = 18'd10000; w_next_digit = r_m1; end
            S_MIN_T: begin w_const = 18'd1000;  w_next_digit = r_m2; end
            S_MIN_U: begin w_const = 18'd100;   w_next_digit = r_s1; end
            S_SEC_T: begin w_const = 18'd10;    w_next_digit = r_s2; end
            S_SEC_U: begin w_const = 18'd1;     w_next_digit = 4'd0; end
            default: begin w_const = 18'd0;     w_next_digit = 4'd0; end
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_podge) w_state_next = S_CHECK;
            S_CHECK: w_state_next = w_valid ? S_HOUR : S_DONE;
            S_HOUR:  if (w_cnt_zero) w_state_next = S_MIN_T;
            S_MIN_T: if (w_cnt_zero) w_state_next = S_MIN_U;
            S_MIN_U: if (w_cnt_zero) w_state_next = S_SEC_T;
            S_SEC_T: if (w_cnt_zero) w_state_next = S_SEC_U;
            S_SEC_U: if (w_cnt_zero) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmp    <= 2'b00;
            r_h1     <= 4'd0;
            r_h2     <= 4'd0;
            r_m1     <= 4'd0;
            r_m2     <= 4'd0;
            r_s1     <= 4'd0;
            r_s2     <= 4'd0;
            r_acc    <= 18'd0;
            r_cnt    <= 5'd0;
            r_err    <= 1'b0;
            shijian  <= 18'd0;
            sj_valid <= 1'b0;
            err      <= 1'b0;
        end else begin
            r_tmp    <= {r_tmp[0], start};
            sj_valid <= 1'b0;
            err      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_podge) begin
                        r_h1 <= shi_1;
                        r_h2 <= shi_2;
                        r_m1 <= fen_1;
                        r_m2 <= fen_2;
                        r_s1 <= miao_1;
                        r_s2 <= miao_2;
                    end
                end
                S_CHECK: begin
                    r_err <= ~w_valid;
                    r_acc <= 18'd0;
                    r_cnt <= w_h_utc;
                end
                S_DONE: begin
                    sj_valid <= 1'b1;
                    err      <= r_err;
                    if (!r_err) shijian <= r_acc;
                end
                default: begin
                    // Accumulate states: spend cnt cycles adding, then load the next digit
                    if (!w_cnt_zero) begin
                        r_acc <= r_acc + w_const;
                        r_cnt <= r_cnt - 5'd1;
                    end else begin
                        r_cnt <= {1'b0, w_next_digit};
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_time_pack_utc.sv
// ============================================================================
// Module   : tb_time_pack_utc
// Brief    : Directed self-checking bench for time_pack_utc.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_time_pack_utc;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  shi_1, shi_2, fen_1, fen_2, miao_1, miao_2;
    logic [17:0] shijian;
    logic        sj_valid;
    logic        err;
    logic        busy;

    int checks = 0;
    int errors = 0;

    time_pack_utc dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .shi_1    (shi_1),
        .shi_2    (shi_2),
        .fen_1    (fen_1),
        .fen_2    (fen_2),
        .miao_1   (miao_1),
        .miao_2   (miao_2),
        .shijian  (shijian),
        .sj_valid (sj_valid),
        .err      (err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drives one conversion from a clean IDLE; start stays high until the end
    task automatic conv(input logic [3:0] h1, input logic [3:0] h2,
                        input logic [3:0] m1, input logic [3:0] m2,
                        input logic [3:0] s1, input logic [3:0] s2,
                        input logic [17:0] exp_val, input logic exp_err,
                        input int exp_lat, input string tag);
        int   lat;
        logic extra;
        lat   = 100;
        extra = 1'b0;
        @(negedge clk);
        shi_1 = h1; shi_2 = h2; fen_1 = m1; fen_2 = m2; miao_1 = s1; miao_2 = s2;
        start = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) begin
                chk({tag, "_busy"}, busy, 1'b1);
                shi_1 = 4'hF; shi_2 = 4'hF; fen_1 = 4'hF;
                fen_2 = 4'hF; miao_1 = 4'hF; miao_2 = 4'hF;
            end
            if (sj_valid) begin
                lat = n;
                break;
            end
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_val"}, shijian, exp_val);
        for (int n = 0; n < 4; n++) begin
            @(posedge clk);
            #1;
            if (sj_valid) extra = 1'b1;
        end
        chk({tag, "_single"}, extra, 1'b0);
        chk({tag, "_idle"}, busy, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int pulses;
        rst_n = 1'b0;
        start = 1'b0;
        shi_1 = 0; shi_2 = 0; fen_1 = 0; fen_2 = 0; miao_1 = 0; miao_2 = 0;
        repeat (3) @(negedge clk);
        chk("rst_shijian", shijian, 18'd0);
        chk("rst_valid", sj_valid, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        conv(0, 8, 0, 0, 0, 0, 18'd0,      1'b0, 8,  "t0800");
        conv(1, 4, 3, 5, 2, 7, 18'd63527,  1'b0, 31, "t1435");
        conv(0, 7, 5, 9, 5, 9, 18'd235959, 1'b0, 59, "t0759");
        conv(0, 0, 0, 0, 0, 0, 18'd160000, 1'b0, 24, "t0000");
        conv(2, 4, 0, 0, 0, 0, 18'd160000, 1'b1, 3,  "e2400");
        conv(1, 2, 6, 0, 0, 0, 18'd160000, 1'b1, 3,  "e1260");
        conv(1, 2, 3, 10, 0, 0, 18'd160000, 1'b1, 3, "edig10");
        conv(2, 3, 5, 9, 5, 9, 18'd155959, 1'b0, 51, "t2359");
        conv(0, 9, 0, 5, 0, 1, 18'd10501,  1'b0, 15, "t0905");

        // Extra start edges while busy must be ignored
        pulses = 0;
        @(negedge clk);
        shi_1 = 1; shi_2 = 4; fen_1 = 3; fen_2 = 5; miao_1 = 2; miao_2 = 7;
        start = 1'b1;
        for (int n = 0; n < 80; n++) begin
            @(negedge clk);
            if (n == 4)  start = 1'b0;
            if (n == 6)  start = 1'b1;
            if (n == 8)  start = 1'b0;
            if (n == 12) start = 1'b1;
            if (n == 14) start = 1'b0;
            if (sj_valid) pulses++;
        end
        chk("retrig_pulses", pulses, 1);
        chk("retrig_val", shijian, 18'd63527);
        conv(2, 0, 1, 1, 1, 1, 18'd121111, 1'b0, 24, "t2011");

        // Reset in the middle of the HOUR phase
        @(negedge clk);
        shi_1 = 0; shi_2 = 7; fen_1 = 5; fen_2 = 9; miao_1 = 5; miao_2 = 9;
        start = 1'b1;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_shijian", shijian, 18'd0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_valid", sj_valid, 1'b0);
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        pulses = 0;
        for (int n = 0; n < 70; n++) begin
            @(negedge clk);
            if (sj_valid) pulses++;
        end
        chk("mid_rst_nopulse", pulses, 0);
        conv(0, 9, 0, 5, 0, 1, 18'd10501, 1'b0, 15, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
